// File: rtl/alarm_sequencer.sv
// alarm_sequencer: drives a beeping speaker tone once the countdown timer
// expires. Each beep is an ON phase (square wave on BZ) followed by a silent
// OFF phase. The sequence repeats until BEEP_MAX beeps have sounded or the user
// presses STOP. Every output comes straight from a flop.
// Optional feature: define ALARM_LED_EN to add a rotating one-hot LED that
// marks the current beep. Without it, LED is tied low and has no register.
module alarm_sequencer #(
    parameter int TONE_DIV = 1,
    parameter int BEEP_ON  = 200,
    parameter int BEEP_OFF = 200,
    parameter int BEEP_MAX = 30
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       START,
    input  logic       STOP,
    output logic       BZ,
    output logic [7:0] LED,
    output logic       ACTIVE,
    output logic       DONE
);

    localparam int PH_MAX = (BEEP_ON > BEEP_OFF) ? BEEP_ON : BEEP_OFF;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int TONE_W = $clog2(TONE_DIV + 1);
    localparam int BEEP_W = $clog2(BEEP_MAX + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;

    state_t              state, state_n;
    logic [PH_W-1:0]     phase_cnt, phase_n;
    logic [TONE_W-1:0]   tone_cnt, tone_n;
    logic [BEEP_W-1:0]   beep_cnt, beep_n;
    logic                bz_n, active_n, done_n;

    // State, counters and registered outputs; reset aborts silently with no DONE
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            phase_cnt <= '0;
            tone_cnt  <= '0;
            beep_cnt  <= '0;
            BZ        <= 1'b0;
            ACTIVE    <= 1'b0;
            DONE      <= 1'b0;
        end else begin
            state     <= state_n;
            phase_cnt <= phase_n;
            tone_cnt  <= tone_n;
            beep_cnt  <= beep_n;
            BZ        <= bz_n;
            ACTIVE    <= active_n;
            DONE      <= done_n;
        end
    end

    // Next-state and next-output logic. STOP outranks START and also outranks the phase timers
    always_comb begin
        state_n  = state;
        phase_n  = phase_cnt;
        tone_n   = tone_cnt;
        beep_n   = beep_cnt;
        bz_n     = BZ;
        active_n = ACTIVE;
        done_n   = 1'b0;

        case (state)
            IDLE: begin
                bz_n     = 1'b0;
                active_n = 1'b0;
                if (START && !STOP) begin
                    state_n  = ON;
                    phase_n  = '0;
                    tone_n   = '0;
                    beep_n   = '0;
                    bz_n     = 1'b1;
                    active_n = 1'b1;
                end
            end

            ON: begin
                if (STOP) begin
                    state_n  = IDLE;
                    bz_n     = 1'b0;
                    active_n = 1'b0;
                end else if (phase_cnt == PH_W'(BEEP_ON - 1)) begin
                    state_n = OFF;
                    phase_n = '0;
                    bz_n    = 1'b0;
                    if (beep_cnt != BEEP_W'(BEEP_MAX)) begin
                        beep_n = beep_cnt + BEEP_W'(1);
                    end
                end else begin
                    phase_n = phase_cnt + PH_W'(1);
                    if (tone_cnt == TONE_W'(TONE_DIV - 1)) begin
                        tone_n = '0;
                        bz_n   = ~BZ;
                    end else begin
                        tone_n = tone_cnt + TONE_W'(1);
                    end
                end
            end

            OFF: begin
                bz_n = 1'b0;
                if (STOP) begin
                    state_n  = IDLE;
                    active_n = 1'b0;
                end else if (phase_cnt == PH_W'(BEEP_OFF - 1)) begin
                    phase_n = '0;
                    if (beep_cnt < BEEP_W'(BEEP_MAX)) begin
                        state_n = ON;
                        tone_n  = '0;
                        bz_n    = 1'b1;
                    end else begin
                        state_n  = IDLE;
                        active_n = 1'b0;
                        done_n   = 1'b1;
                    end
                end else begin
                    phase_n = phase_cnt + PH_W'(1);
                end
            end

            default: begin
                state_n  = IDLE;
                bz_n     = 1'b0;
                active_n = 1'b0;
            end
        endcase
    end

`ifdef ALARM_LED_EN
    logic [7:0] led_n;

    // One-hot beep marker derived from the upcoming state; completed beep count picks the bit
    always_comb begin
        led_n = 8'h00;
        if (state_n == ON) begin
            led_n = 8'h01 << (32'(beep_n) % 32'd8);
        end
    end

    // LED register, cleared by reset like the other outputs
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            LED <= 8'h00;
        end else begin
            LED <= led_n;
        end
    end
`else
    assign LED = 8'h00;
`endif

endmodule

// File: tb/tb_alarm_sequencer.sv
// tb_alarm_sequencer: table-driven checks of alarm_sequencer with short
// phases (TONE_DIV=1, BEEP_ON=4, BEEP_OFF=4, BEEP_MAX=3). Expected outputs
// are queued when inputs are driven and popped when the outputs are sampled.
module tb_alarm_sequencer;

    localparam int TONE_DIV = 1;
    localparam int BEEP_ON  = 4;
    localparam int BEEP_OFF = 4;
    localparam int BEEP_MAX = 3;
    localparam int PERIOD   = BEEP_ON + BEEP_OFF;
    localparam int RUN_LEN  = PERIOD * BEEP_MAX;

`ifdef ALARM_LED_EN
    localparam logic [7:0] LED_MASK = 8'hFF;
`else
    localparam logic [7:0] LED_MASK = 8'h00;
`endif

    logic       CLOCK;
    logic       RESET;
    logic       START;
    logic       STOP;
    logic       BZ;
    logic [7:0] LED;
    logic       ACTIVE;
    logic       DONE;

    typedef struct {
        logic       start;
        logic       stop;
        logic       bz;
        logic       active;
        logic       done;
        logic [7:0] led;
        string      name;
    } vec_t;

    vec_t vectors[$];
    vec_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    alarm_sequencer #(
        .TONE_DIV (TONE_DIV),
        .BEEP_ON  (BEEP_ON),
        .BEEP_OFF (BEEP_OFF),
        .BEEP_MAX (BEEP_MAX)
    ) dut (
        .CLOCK  (CLOCK),
        .RESET  (RESET),
        .START  (START),
        .STOP   (STOP),
        .BZ     (BZ),
        .LED    (LED),
        .ACTIVE (ACTIVE),
        .DONE   (DONE)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    function automatic logic [7:0] led_for(input int beep);
        logic [7:0] onehot;
        onehot = 8'h01 << (beep % 8);
        return onehot & LED_MASK;
    endfunction

    function automatic vec_t mk_vec(input logic st, input logic sp, input logic bz,
                                    input logic act, input logic dn, input logic [7:0] led,
                                    input string name);
        vec_t v;
        v.start  = st;
        v.stop   = sp;
        v.bz     = bz;
        v.active = act;
        v.done   = dn;
        v.led    = led;
        v.name   = name;
        return v;
    endfunction

    // Expected outputs after edge i of an uninterrupted run (START at edge 0)
    function automatic vec_t exp_run_vec(input int i, input string name);
        int   phase;
        int   beep;
        logic on;
        if (i == RUN_LEN) return mk_vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, {name, " done"});
        if (i > RUN_LEN)  return mk_vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, {name, " idle"});
        phase = i % PERIOD;
        beep  = i / PERIOD;
        on    = (phase < BEEP_ON);
        return mk_vec(i == 0, 1'b0, on && (phase % 2 == 0), 1'b1, 1'b0,
                      on ? led_for(beep) : 8'h00, name);
    endfunction

    task automatic add_run(input string name, input int restart_at, input int stop_at);
        vec_t v;
        for (int i = 0; i <= RUN_LEN + 1; i++) begin
            if (i == stop_at) begin
                vectors.push_back(mk_vec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, {name, " stop"}));
                vectors.push_back(mk_vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, {name, " after stop"}));
                vectors.push_back(mk_vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, {name, " after stop"}));
                return;
            end
            v = exp_run_vec(i, name);
            if (i == restart_at) v.start = 1'b1;
            vectors.push_back(v);
        end
    endtask

    task automatic checkOutput();
        vec_t e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("[TB] FAIL scoreboard: got empty queue, want a pending expectation");
            return;
        end
        e = exp_q.pop_front();
        n_vec++;
        if (BZ !== e.bz || ACTIVE !== e.active || DONE !== e.done || LED !== e.led) begin
            n_bad++;
            $display("[TB] FAIL %s @%0t: got bz=%b active=%b done=%b led=%h, want bz=%b active=%b done=%b led=%h",
                     e.name, $time, BZ, ACTIVE, DONE, LED, e.bz, e.active, e.done, e.led);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge CLOCK);
        START = v.start;
        STOP  = v.stop;
        exp_q.push_back(v);
        @(posedge CLOCK);
        #1;
        checkOutput();
    endtask

    initial begin
        RESET = 1'b1;
        START = 1'b0;
        STOP  = 1'b0;
        repeat (2) @(posedge CLOCK);
        #1;
        exp_q.push_back(mk_vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, "reset state"));
        checkOutput();
        @(negedge CLOCK);
        RESET = 1'b0;

        vectors.push_back(mk_vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, "idle"));
        vectors.push_back(mk_vec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "stop in idle"));
        vectors.push_back(mk_vec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "start+stop idle"));
        vectors.push_back(mk_vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, "idle after start+stop"));
        add_run("full run", -1, -1);
        add_run("start ignored", PERIOD + 1, -1);
        add_run("manual stop", -1, PERIOD + 2);
        add_run("run after stop", -1, -1);

        $display("[TB] applying %0d table vectors", vectors.size());
        for (int i = 0; i < vectors.size(); i++) begin
            applyStimulus(vectors[i]);
        end

        // Reset asserted between edges while the first beep is silent
        for (int i = 0; i < BEEP_ON + 2; i++) begin
            applyStimulus(exp_run_vec(i, "pre-reset run"));
        end
        #2;
        RESET = 1'b1;
        #1;
        exp_q.push_back(mk_vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, "async reset"));
        checkOutput();
        @(posedge CLOCK);
        #1;
        exp_q.push_back(mk_vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, "reset held"));
        checkOutput();
        @(negedge CLOCK);
        RESET = 1'b0;
        for (int i = 0; i < RUN_LEN + 4; i++) begin
            applyStimulus(mk_vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, "post-reset idle"));
        end
        applyStimulus(exp_run_vec(0, "start after reset"));
        applyStimulus(exp_run_vec(1, "start after reset"));
        applyStimulus(mk_vec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "final stop"));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
